ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 138 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_port_arbiter
//  Purpose  : Shares one single-port RAM among N_REQ requesters. A round-robin
//             arbiter grants one requester per cycle, drives the RAM port from
//             the winner, and tracks reads through an RD_LATENCY-deep pipeline
//             so each return is tagged with the reader's index.
//  Options  : RAM_ARB_FIXED_PRIORITY_EN -- when defined, lowest index always
//             wins and the round-robin pointer is not built.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
  parameter int N_REQ      = 4,
  parameter int RAM_WIDTH  = 18,
  parameter int RAM_DEPTH  = 1024,
  parameter int RD_LATENCY = 2,
  // Address bits needed to reach entry RAM_DEPTH-1
  localparam int AW        = $clog2(RAM_DEPTH),
  // Requester index width; N_REQ >= 2 keeps this at least one bit
  localparam int IDW       = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           we,
  input  logic [N_REQ*AW-1:0]        addr,
  input  logic [N_REQ*RAM_WIDTH-1:0] din,
  output logic [N_REQ-1:0]           gnt,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [AW-1:0]              ram_addr,
  output logic [RAM_WIDTH-1:0]       ram_din,
  output logic                       ram_regce,
  input  logic [RAM_WIDTH-1:0]       ram_dout,
  output logic                       rd_valid,
  output logic [IDW-1:0]             rd_id,
  output logic [RAM_WIDTH-1:0]       rd_data
);

  logic [N_REQ-1:0]                w_gnt;
  logic [IDW-1:0]                  w_gidx;
  logic                            w_acc;
  logic [IDW-1:0]                  w_start;
  logic                            w_rd_acc;
  logic [RD_LATENCY-1:0]           r_vld;
  logic [RD_LATENCY-1:0][IDW-1:0]  r_id;

`ifdef RAM_ARB_FIXED_PRIORITY_EN
  // Fixed priority: the search always begins at requester 0
  assign w_start = '0;
`else
  logic [IDW-1:0] r_ptr;

  // Round-robin pointer moves just past the requester that was accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_acc) begin
      r_ptr <= (w_gidx == IDW'(N_REQ - 1)) ? '0 : w_gidx + 1'b1;
    end
  end

  assign w_start = r_ptr;
`endif

  // Pick the first requesting index at or above the start point, wrapping
  always_comb begin
    int v_idx;
    v_idx  = 0;
    w_gnt  = '0;
    w_gidx = '0;
    w_acc  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      v_idx = int'(w_start) + k;
      if (v_idx >= N_REQ) v_idx = v_idx - N_REQ;
      if (!w_acc && req[v_idx]) begin
        w_acc        = 1'b1;
        w_gidx       = IDW'(v_idx);
        w_gnt[v_idx] = 1'b1;
      end
    end
    // No grants while reset is held, even though req may be high
    if (!rst_n) begin
      w_gnt  = '0;
      w_gidx = '0;
      w_acc  = 1'b0;
    end
  end

  assign gnt = w_gnt;

  // Steer the granted requester onto the RAM port; idle port is all zeros
  always_comb begin
    ram_en   = w_acc;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        ram_we   = we[i];
        ram_addr = addr[i*AW +: AW];
        ram_din  = din[i*RAM_WIDTH +: RAM_WIDTH];
      end
    end
  end

  assign w_rd_acc = w_acc & ~ram_we;

  // Read-tracking pipeline: one stage per cycle of RAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_id  <= '0;
    end else begin
      r_vld[0] <= w_rd_acc;
      r_id[0]  <= w_rd_acc ? w_gidx : '0;
      for (int s = 1; s < RD_LATENCY; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_id[s]  <= r_id[s-1];
      end
    end
  end

  assign rd_valid = r_vld[RD_LATENCY-1];
  assign rd_id    = r_id[RD_LATENCY-1];
  assign rd_data  = rd_valid ? ram_dout : '0;

  // Output-register clock enable only matters for the two-cycle RAM
  generate
    if (RD_LATENCY == 2) begin : g_regce_pipe
      assign ram_regce = r_vld[0];
    end else begin : g_regce_const
      assign ram_regce = 1'b1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_port_arbiter
//  Purpose  : Self-checking bench for ram_port_arbiter with a behavioural RAM
//             and a transaction-level reference model (grant order, shadow
//             memory, queue of expected read returns).
//  Options  : RAM_ARB_FIXED_PRIORITY_EN selects fixed-priority expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter #(
  parameter int LAT = 2
);
  localparam int N   = 4;
  localparam int W   = 18;
  localparam int D   = 1024;
  localparam int AW  = 10;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req, we, gnt;
  logic [N*AW-1:0]  addr;
  logic [N*W-1:0]   din;
  logic             ram_en, ram_we, ram_regce, rd_valid;
  logic [AW-1:0]    ram_addr;
  logic [W-1:0]     ram_din, ram_dout, rd_data;
  logic [IDW-1:0]   rd_id;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .N_REQ(N), .RAM_WIDTH(W), .RAM_DEPTH(D), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .din(din),
    .gnt(gnt), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_regce(ram_regce), .ram_dout(ram_dout),
    .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data)
  );

  // Behavioural single-port RAM with optional output register
  logic [W-1:0] mem [D];
  logic [W-1:0] q1, q2;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        q1 <= mem[ram_addr];
    end
    if (ram_regce) q2 <= q1;
  end
  assign ram_dout = (LAT == 1) ? q1 : q2;

  // Reference model state
  typedef struct { int due; int id; logic [W-1:0] data; } rd_t;
  rd_t          exp_q[$];
  logic [W-1:0] shadow [D];
  int           m_ptr, cyc, last_g;
  bit           m_rd_last;
  int           n_cmp, n_bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    int start;
`ifdef RAM_ARB_FIXED_PRIORITY_EN
    start = 0;
`else
    start = m_ptr;
`endif
    for (int k = 0; k < N; k++) begin
      if (req[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic set_rq(input int i, input bit r, input bit w, input int a, input logic [W-1:0] d);
    req[i]          = r;
    we[i]           = w;
    addr[i*AW +: AW] = AW'(a);
    din[i*W +: W]   = d;
  endtask

  // One clock: check mid-cycle against the model, then advance the model
  task automatic step();
    int            g;
    logic [N-1:0]  eg;
    bit            ev;
    int            a;
    @(negedge clk);
    g  = pick();
    eg = (g >= 0) ? (N'(1) << g) : '0;
    chk("gnt", 64'(gnt), 64'(eg));
    chk("ram_en", 64'(ram_en), 64'(g >= 0));
    if (g >= 0) begin
      a = int'(addr[g*AW +: AW]);
      chk("ram_we", 64'(ram_we), 64'(we[g]));
      chk("ram_addr", 64'(ram_addr), 64'(a));
      chk("ram_din", 64'(ram_din), 64'(din[g*W +: W]));
    end else begin
      chk("idle_port", {ram_we, ram_addr, ram_din}, 64'd0);
    end
    ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    chk("rd_valid", 64'(rd_valid), 64'(ev));
    if (ev) begin
      chk("rd_id", 64'(rd_id), 64'(exp_q[0].id));
      chk("rd_data", 64'(rd_data), 64'(exp_q[0].data));
      void'(exp_q.pop_front());
    end else begin
      chk("rd_data_idle", 64'(rd_data), 64'd0);
    end
    chk("ram_regce", 64'(ram_regce), (LAT == 1) ? 64'd1 : 64'(m_rd_last));
    m_rd_last = 1'b0;
    if (g >= 0) begin
      if (we[g]) begin
        shadow[a] = din[g*W +: W];
      end else begin
        exp_q.push_back('{due: cyc + LAT, id: g, data: shadow[a]});
        m_rd_last = 1'b1;
      end
      m_ptr = (g + 1) % N;
    end
    last_g = g;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int k = 0; k < n; k++) step();
  endtask

  // Pulse reset for one clock edge, checking forced outputs while it is low
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_ram_en", 64'(ram_en), 64'd0);
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_id", 64'(rd_id), 64'd0);
    exp_q.delete();
    m_ptr     = 0;
    m_rd_last = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; m_ptr = 0; last_g = -1; m_rd_last = 1'b0;
    rst_n = 1'b0;
    req = '1; we = '0; addr = '0; din = '0;

    // Reset state with every requester asking
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", 64'(gnt), 64'd0);
    chk("reset_ram_en", 64'(ram_en), 64'd0);
    chk("reset_ram_we", 64'(ram_we), 64'd0);
    chk("reset_ram_addr", 64'(ram_addr), 64'd0);
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_rd_id", 64'(rd_id), 64'd0);
    chk("reset_rd_data", 64'(rd_data), 64'd0);
    req   = '0;
    rst_n = 1'b1;

    // Preload addresses 0..15 with all requesters writing concurrently
    for (int s = 0; s < 16; s++) begin
      for (int i = 0; i < N; i++) begin
        int a;
        a = 4 * (s / 4) + i;
        set_rq(i, 1'b1, 1'b1, a, W'(a * 37 + 5));
      end
      step();
    end

    // All requesters reading for 8 cycles: rotation 0,1,2,3,0,1,2,3
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < N; i++) set_rq(i, 1'b1, 1'b0, (s * 3 + i) % 16, '0);
      step();
    end
    idle(LAT + 1);

    // Write then read the same location from different requesters
    req = '0;
    set_rq(0, 1'b1, 1'b1, 5, 18'h155);
    step();
    req = '0;
    set_rq(2, 1'b1, 1'b0, 5, '0);
    step();
    idle(LAT + 1);

    // Lone requester 3 reading three times, then requester 1
    req = '0;
    for (int s = 0; s < 3; s++) begin
      set_rq(3, 1'b1, 1'b0, s + 1, '0);
      step();
    end
    req = '0;
    set_rq(1, 1'b1, 1'b0, 9, '0);
    step();
    idle(LAT + 1);

    // Two reads in flight, then reset before they return
    req = '0;
    set_rq(1, 1'b1, 1'b0, 2, '0);
    set_rq(2, 1'b1, 1'b0, 3, '0);
    step();
    step();
    reset_pulse();
    for (int i = 0; i < N; i++) set_rq(i, 1'b1, 1'b0, i, '0);
    step();
    idle(LAT + 2);

    // Requesters 1 and 3 held high
    req = '0;
    set_rq(1, 1'b1, 1'b0, 4, '0);
    set_rq(3, 1'b1, 1'b0, 6, '0);
    for (int s = 0; s < 4; s++) begin
`ifdef RAM_ARB_FIXED_PRIORITY_EN
      chk("fixed_gnt", 64'(gnt), 64'b0010);
`endif
      step();
    end
    idle(LAT + 1);

    // Randomized traffic; pending requests hold until accepted
    req = '0;
    last_g = -1;
    for (int s = 0; s < 400; s++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] || last_g == i) begin
          set_rq(i, ($urandom_range(0, 9) < 6), $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 15)), W'($urandom));
        end
      end
      step();
    end
    idle(LAT + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
